imem_loader: RTL and testbench

Boot-time instruction-memory loader upstream of the instruction ROM. It accepts a byte stream over a valid/ready handshake, assembles 32-bit big-endian words and writes them into imem through its write port. It holds the processor in reset until the image is complete. The top level muxes the ROM address, data and write-enable between this block (while `cpu_reset`=1) and the processor's `address_imem`.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader_word_assembler.sv | 46 ++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        WORD,
        WRITE,
        DONE,
        ERROR
    } state_e;

    // Header length in bytes (16-bit word count, MSB first)
    localparam int unsigned COUNT_BYTES    = 2;
    // Bytes per imem word (big-endian)
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage : loader_pkg

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake between the upstream source and the loader.
interface imem_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    // Upstream byte source
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    // Loader side
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface : imem_loader_if

// File: rtl/imem_loader_word_assembler.sv
// 32-bit big-endian word assembler: shifts bytes in MSB first and tracks
// how many bytes of the current word have arrived.
module loader_word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q,  cnt_d;

    // Next-state: clear restarts the byte count, shift appends a byte at the LSB
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            word_d = {word_q[23:0], byte_in};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;
    // High while the last byte slot is pending: the next shift completes the
    // word, and the counter wraps back to zero on its own.
    assign word_full = (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule : loader_word_assembler

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a counted byte image,
// assembles big-endian words, writes them to imem and holds the CPU in
// reset until the image is complete.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    imem_loader_if.slave          rx,
    output logic                  imem_wren,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                  wren_q, wren_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic        accept;
    logic [15:0] count_full;
    logic        last_word;
    logic [31:0] asm_word;
    logic        asm_full;
    logic        asm_shift;
    logic        asm_clear;

    // Ready is decoded straight from state; everything else is registered
    always_comb begin
        rx.rx_ready = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == WORD);
    end

    assign accept     = rx.rx_valid && rx.rx_ready;
    assign count_full = {count_q[15:8], rx.rx_data};
    assign last_word  = ((17'(word_idx_q) + 17'd1) == {1'b0, count_q});
    assign asm_shift  = (state_q == WORD) && accept;
    assign asm_clear  = (state_q == CNT_LO) && accept;

    loader_word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (asm_shift),
        .clear     (asm_clear),
        .byte_in   (rx.rx_data),
        .word      (asm_word),
        .word_full (asm_full)
    );

    // FSM next-state, header/index bookkeeping and output decode of next state
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        case (state_q)
            CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = rx.rx_data;
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (accept) begin
                    count_d = count_full;
                    if (count_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, count_full} > CAPACITY) begin
                        state_d = ERROR;
                    end else begin
                        word_idx_d = '0;
                        state_d    = WORD;
                    end
                end
            end
            WORD: begin
                if (accept && asm_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = WORD;
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = CNT_HI;
        endcase

        wren_d      = (state_d == WRITE);
        cpu_reset_d = (state_d != DONE);
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERROR);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= CNT_HI;
            count_q     <= '0;
            word_idx_q  <= '0;
            wren_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            wren_q      <= wren_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_wren = wren_q;
    assign imem_addr = word_idx_q;
    assign imem_data = DATA_WIDTH'(asm_word);
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          imem_wren;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_loader_if rx_if ();

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx_if.slave),
        .imem_wren (imem_wren),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned wr_cyc[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    logic [AW-1:0] last_addr = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next scoreboard entry
    always @(negedge clock) begin
        if (imem_wren === 1'b1) begin
            wr_t e;
            writes++;
            wr_cyc.push_back(cyc);
            last_addr = imem_addr;
            chk("rdy_in_write", 32'(rx_if.rx_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write addr=%h data=%h expected=none", imem_addr, imem_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.a));
                chk("wr_data", imem_data, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        int n;
        n = 0;
        @(negedge clock);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        while (rx_if.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL send_timeout byte=%h observed=no_ready expected=ready", b);
            rx_if.rx_valid = 1'b0;
        end else begin
            @(posedge clock);
            if (toggle) begin
                @(negedge clock);
                rx_if.rx_valid = 1'b0;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a, input bit toggle);
        exp_q.push_back('{a: a, d: w});
        send_byte(w[31:24], toggle);
        send_byte(w[23:16], toggle);
        send_byte(w[15:8],  toggle);
        send_byte(w[7:0],   toggle);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b1;
        rx_if.rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_rx_ready",  32'(rx_if.rx_ready), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset),      32'd1);
        chk("rst_done",      32'(done),           32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    int w0;

    initial begin
        reset          = 1'b1;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("init_wren",      32'(imem_wren),      32'd0);
        chk("init_addr",      32'(imem_addr),      32'd0);
        chk("init_data",      imem_data,           32'd0);
        chk("init_cpu_reset", 32'(cpu_reset),      32'd1);
        chk("init_done",      32'(done),           32'd0);
        chk("init_error",     32'(error),          32'd0);
        chk("init_rx_ready",  32'(rx_if.rx_ready), 32'd1);

        // N=2, valid held high
        w0 = writes;
        wr_cyc.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h1234_5678, 12'd0, 1'b0);
        send_word(32'hDEAD_BEEF, 12'd1, 1'b0);
        @(negedge clock);
        rx_if.rx_valid = 1'b0;
        chk("t1_done_early", 32'(done),      32'd0);
        chk("t1_cpurst_early", 32'(cpu_reset), 32'd1);
        @(negedge clock);
        chk("t1_done",       32'(done),      32'd1);
        chk("t1_cpu_reset",  32'(cpu_reset), 32'd0);
        chk("t1_writes",     32'(writes - w0), 32'd2);
        if (wr_cyc.size() == 2)
            chk("t1_spacing", wr_cyc[1] - wr_cyc[0], 32'd5);
        else
            chk("t1_spacing_count", 32'(wr_cyc.size()), 32'd2);

        // Same image, valid toggling
        do_reset();
        w0 = writes;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h1234_5678, 12'd0, 1'b1);
        send_word(32'hDEAD_BEEF, 12'd1, 1'b1);
        wait_done();
        chk("t2_cpu_reset", 32'(cpu_reset),      32'd0);
        chk("t2_writes",    32'(writes - w0),    32'd2);
        chk("t2_sb_empty",  32'(exp_q.size()),   32'd0);

        // Empty image
        do_reset();
        w0 = writes;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clock);
        rx_if.rx_valid = 1'b0;
        chk("t3_done",      32'(done),        32'd1);
        chk("t3_cpu_reset", 32'(cpu_reset),   32'd0);
        chk("t3_writes",    32'(writes - w0), 32'd0);

        // Oversized header 4097
        do_reset();
        w0 = writes;
        send_byte(8'h10, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clock);
        chk("t4_error",     32'(error),          32'd1);
        chk("t4_cpu_reset", 32'(cpu_reset),      32'd1);
        chk("t4_rx_ready",  32'(rx_if.rx_ready), 32'd0);
        chk("t4_done",      32'(done),           32'd0);
        repeat (4) @(negedge clock);
        rx_if.rx_valid = 1'b0;
        chk("t4_writes",    32'(writes - w0),    32'd0);

        // Exact-capacity header 4096
        do_reset();
        w0 = writes;
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 4096; i++)
            send_word(32'(i) * 32'h0001_0003 ^ 32'hA5C3_0F1E, AW'(i), 1'b0);
        wait_done();
        rx_if.rx_valid = 1'b0;
        chk("t5_writes",    32'(writes - w0), 32'd4096);
        chk("t5_last_addr", 32'(last_addr),   32'h0FFF);
        chk("t5_error",     32'(error),       32'd0);

        // Reset after 6 bytes of an N=3 image
        do_reset();
        w0 = writes;
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(32'hCAFE_F00D, 12'd0, 1'b0);
        @(negedge clock);
        reset          = 1'b1;
        rx_if.rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("t6_writes",    32'(writes - w0),    32'd1);
        chk("t6_sb_empty",  32'(exp_q.size()),   32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset),      32'd1);
        chk("t6_rx_ready",  32'(rx_if.rx_ready), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'h0BAD_C0DE, 12'd0, 1'b0);
        wait_done();
        chk("t6_writes2",   32'(writes - w0),    32'd2);
        chk("t6_last_addr", 32'(last_addr),      32'd0);

        // Bytes offered in DONE are refused
        w0 = writes;
        rx_if.rx_data  = 8'h55;
        rx_if.rx_valid = 1'b1;
        repeat (5) @(negedge clock);
        chk("t7_rx_ready", 32'(rx_if.rx_ready), 32'd0);
        chk("t7_done",     32'(done),           32'd1);
        chk("t7_writes",   32'(writes - w0),    32'd0);
        rx_if.rx_valid = 1'b0;

        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader
